ps2_host_rx: RTL
================

Name: ps2_host_rx

Overview:
- Host-side PS/2 receiver running in the clk_sys domain.
- Deserialises the 11-bit frames produced by the PS/2 keyboard/mouse emulation lines (or a physical PS/2 device) into bytes.
- Checks parity and framing, and aborts stalled frames on a timeout.
- Includes a keyboard prefix decoder (E0/F0) that presents complete key events to the core's keyboard matrix logic. Mouse cores use the raw byte outputs only.

Parameters:
- FILTER, 8: number of consecutive equal synchronised ps2_clk samples required before the filtered clock changes level (2..255).
- TIMEOUT, 4000: clk_sys cycles without a filtered falling edge, mid-frame, before the frame is aborted (16-bit).

Ports:
- clk_sys  in  1  system clock; all logic on its rising edge.
- reset_n  in  1  asynchronous active-low reset.
- ps2_clk  in  1  PS/2 clock line, asynchronous to clk_sys.
- ps2_data  in  1  PS/2 data line, asynchronous to clk_sys.
- rx_data  out  8  last correctly received byte.
- rx_valid  out  1  one-cycle strobe; rx_data is updated in the same cycle.
- parity_err  out  1  one-cycle strobe on an odd-parity failure.
- frame_err  out  1  one-cycle strobe on a bad stop bit or a timeout.
- busy  out  1  high while a frame is in progress (state != IDLE).
- key_strobe  out  1  one-cycle strobe when a complete key event is available.
- key_code  out  8  scancode of the event (prefixes stripped).
- key_pressed  out  1  1 = make, 0 = break (F0 seen).
- key_extended  out  1  1 = E0 prefix seen.

Behaviour:
- Reset, asynchronous (reset_n low): all outputs 0; state IDLE; filtered clock 1; prefix flags cleared; sync FFs 1.
- Synchronisation: ps2_clk and ps2_data each pass through a 2-FF synchroniser.
- Clock filter: the filtered clock takes the synchronised level after FILTER consecutive equal samples. A fall event is a 1 to 0 change of the filtered clock. Synchronised ps2_data is sampled in the cycle of the fall event.
- FSM, advanced only on fall events:
  - IDLE: sample 0 → DATA with bit_cnt=0 and parity accumulator cleared. Sample 1 → stay in IDLE (spurious edge ignored, no error).
  - DATA: shift the sample into shreg LSB-first, bit_cnt+1. After the 8th bit → PARITY.
  - PARITY: store the sample → STOP.
  - STOP:
    - Sample 1 and (XOR of 8 data bits and parity bit) = 1 → rx_valid=1 and rx_data=shreg in the following cycle.
    - Sample 1 and that XOR = 0 → parity_err=1 only.
    - Sample 0 → frame_err=1 only (a bad stop bit takes priority over parity).
    - All three cases return to IDLE.
- Latency: rx_valid is asserted exactly 1 clk_sys cycle after the fall event that samples the stop bit.
- Timeout:
  - The counter resets on every fall event and in IDLE, and increments otherwise.
  - When it reaches TIMEOUT in a non-IDLE state: frame_err=1 for 1 cycle, state → IDLE, partial byte discarded, prefix flags cleared.
- Errors: parity_err and frame_err also clear the prefix flags. rx_data holds its previous value on any error.
- Strobes: rx_valid, parity_err and frame_err are mutually exclusive per cycle.
- Key decoder, evaluated on each rx_valid:
  - Byte F0 → set rel flag, no strobe.
  - Byte E0 → set ext flag, no strobe.
  - Any other byte → key_strobe=1 the cycle after rx_valid, with key_code=byte, key_pressed=~rel and key_extended=ext, then both flags are cleared.
  - key_code, key_pressed and key_extended hold their values until the next key_strobe.
  - Bytes E1, AA and FA are passed through as ordinary codes.
- Line release mid-frame (clock stays high) ends only via the timeout.
- Reset mid-frame aborts immediately; no strobe is emitted.

Test Plan:
- Send 0x1C (bits 0,0,1,1,1,0,0,0, parity 0, stop 1) at 200 clk_sys per bit, FILTER=8 → a single rx_valid with rx_data=0x1C, 1 cycle after the stop-bit fall event. Then key_strobe with key_code=0x1C, pressed=1, extended=0.
- Send F0 then 1C → one rx_valid per byte, exactly one key_strobe with code 0x1C, pressed=0, extended=0. Send E0, F0, 75 → key_strobe with code 0x75, pressed=0, extended=1.
- Send 0x1C with parity bit 1 → parity_err pulse, no rx_valid, rx_data unchanged. Send 0x1C with stop bit 0 → frame_err pulse only. A following good 0x29 → rx_valid with rx_data=0x29.
- Stop the clock after 4 data bits for 4001 cycles → frame_err exactly at cycle TIMEOUT, busy goes low. Send E0, stall, then 0x75 → the 0x75 event has extended=0.
- Inject 3-cycle glitches (shorter than FILTER) on ps2_clk in IDLE and mid-frame → no state change, and the byte is still received correctly.
- Assert reset_n low during bit 5 → all outputs 0 immediately, no strobes. After release, 0x5A → rx_valid with rx_data=0x5A.

Source files
------------

// File: rtl/ps2_host_rx_if.sv
// PS/2 receiver bus: the two PS/2 lines plus the byte and key-event outputs.
// The receiver uses the slave modport; the line driver/consumer uses master.
interface ps2_host_rx_if;
  logic       ps2_clk;
  logic       ps2_data;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       parity_err;
  logic       frame_err;
  logic       busy;
  logic       key_strobe;
  logic [7:0] key_code;
  logic       key_pressed;
  logic       key_extended;

  modport master (
    output ps2_clk, ps2_data,
    input  rx_data, rx_valid, parity_err, frame_err, busy,
    input  key_strobe, key_code, key_pressed, key_extended
  );

  modport slave (
    input  ps2_clk, ps2_data,
    output rx_data, rx_valid, parity_err, frame_err, busy,
    output key_strobe, key_code, key_pressed, key_extended
  );
endinterface

// File: rtl/ps2_host_rx.sv
// Host-side PS/2 frame receiver with clock glitch filter, stall timeout and
// an E0/F0 prefix decoder that turns scancode bytes into key events.
module ps2_host_rx #(
  parameter int unsigned FILTER  = 8,
  parameter logic [15:0] TIMEOUT = 16'd4000
) (
  input logic          clk_sys,
  input logic          reset_n,
  ps2_host_rx_if.slave bus
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_DATA   = 2'd1;
  localparam logic [1:0] S_PARITY = 2'd2;
  localparam logic [1:0] S_STOP   = 2'd3;

  localparam logic [7:0] FILTER_M1 = 8'(FILTER - 1);

  logic       clk_s1_q, clk_s2_q, dat_s1_q, dat_s2_q;
  logic       filt_q, filt_d;
  logic [7:0] fcnt_q, fcnt_d;
  logic       fall;

  logic [1:0]  state_q, state_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  shreg_q, shreg_d;
  logic        par_q, par_d;
  logic [15:0] to_cnt_q, to_cnt_d;

  logic [7:0] rx_data_q, rx_data_d;
  logic       rx_valid_q, rx_valid_d;
  logic       perr_q, perr_d;
  logic       ferr_q, ferr_d;

  logic       rel_q, rel_d;
  logic       ext_q, ext_d;
  logic       ks_q, ks_d;
  logic [7:0] kc_q, kc_d;
  logic       kp_q, kp_d;
  logic       ke_q, ke_d;

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      clk_s1_q <= 1'b1;
      clk_s2_q <= 1'b1;
      dat_s1_q <= 1'b1;
      dat_s2_q <= 1'b1;
    end else begin
      clk_s1_q <= bus.ps2_clk;
      clk_s2_q <= clk_s1_q;
      dat_s1_q <= bus.ps2_data;
      dat_s2_q <= dat_s1_q;
    end
  end

  // fcnt counts consecutive samples that disagree with the filtered level.
  always_comb begin
    filt_d = filt_q;
    fcnt_d = '0;
    if (clk_s2_q != filt_q) begin
      if (fcnt_q == FILTER_M1) begin
        filt_d = clk_s2_q;
      end else begin
        fcnt_d = fcnt_q + 8'd1;
      end
    end
  end

  assign fall = filt_q & ~filt_d;

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    shreg_d    = shreg_q;
    par_d      = par_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    perr_d     = 1'b0;
    ferr_d     = 1'b0;
    to_cnt_d   = (state_q == S_IDLE || fall) ? '0 : to_cnt_q + 16'd1;
    if (fall) begin
      case (state_q)
        S_IDLE: begin
          if (!dat_s2_q) begin
            state_d   = S_DATA;
            bit_cnt_d = '0;
            par_d     = 1'b0;
          end
        end
        S_DATA: begin
          shreg_d   = {dat_s2_q, shreg_q[7:1]};
          par_d     = par_q ^ dat_s2_q;
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_d = S_PARITY;
        end
        S_PARITY: begin
          par_d   = par_q ^ dat_s2_q;
          state_d = S_STOP;
        end
        default: begin
          state_d = S_IDLE;
          if (!dat_s2_q) begin
            ferr_d = 1'b1;
          end else if (par_q) begin
            rx_valid_d = 1'b1;
            rx_data_d  = shreg_q;
          end else begin
            perr_d = 1'b1;
          end
        end
      endcase
    end else if (state_q != S_IDLE && to_cnt_q == TIMEOUT) begin
      ferr_d  = 1'b1;
      state_d = S_IDLE;
    end
  end

  // Prefix flags are consumed by the first non-prefix byte or dropped on any error.
  always_comb begin
    rel_d = rel_q;
    ext_d = ext_q;
    ks_d  = 1'b0;
    kc_d  = kc_q;
    kp_d  = kp_q;
    ke_d  = ke_q;
    if (perr_q || ferr_q) begin
      rel_d = 1'b0;
      ext_d = 1'b0;
    end else if (rx_valid_q) begin
      case (rx_data_q)
        8'hF0: rel_d = 1'b1;
        8'hE0: ext_d = 1'b1;
        default: begin
          ks_d  = 1'b1;
          kc_d  = rx_data_q;
          kp_d  = ~rel_q;
          ke_d  = ext_q;
          rel_d = 1'b0;
          ext_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      filt_q     <= 1'b1;
      fcnt_q     <= '0;
      state_q    <= S_IDLE;
      bit_cnt_q  <= '0;
      shreg_q    <= '0;
      par_q      <= 1'b0;
      to_cnt_q   <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
      rel_q      <= 1'b0;
      ext_q      <= 1'b0;
      ks_q       <= 1'b0;
      kc_q       <= '0;
      kp_q       <= 1'b0;
      ke_q       <= 1'b0;
    end else begin
      filt_q     <= filt_d;
      fcnt_q     <= fcnt_d;
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shreg_q    <= shreg_d;
      par_q      <= par_d;
      to_cnt_q   <= to_cnt_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      perr_q     <= perr_d;
      ferr_q     <= ferr_d;
      rel_q      <= rel_d;
      ext_q      <= ext_d;
      ks_q       <= ks_d;
      kc_q       <= kc_d;
      kp_q       <= kp_d;
      ke_q       <= ke_d;
    end
  end

  assign bus.rx_data      = rx_data_q;
  assign bus.rx_valid     = rx_valid_q;
  assign bus.parity_err   = perr_q;
  assign bus.frame_err    = ferr_q;
  assign bus.busy         = (state_q != S_IDLE);
  assign bus.key_strobe   = ks_q;
  assign bus.key_code     = kc_q;
  assign bus.key_pressed  = kp_q;
  assign bus.key_extended = ke_q;

endmodule
